serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when sum and cout become valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result of a+b+cin, modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: carry-out of the addition.

Function
REQ-012 The block SHALL compute the sum bit-serially, LSB first, one bit per clk cycle, through exactly one full-adder cell.
REQ-013 The block SHALL implement the states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 SHALL be accepted: capture a, b and cin, clear the bit counter, and go to RUN.
REQ-015 In IDLE, start=0 SHALL keep the block in IDLE.
REQ-016 In RUN, each edge SHALL perform these steps: feed bit[cnt] of A, bit[cnt] of B and the carry register into the full adder; shift the sum bit into the sum register at position cnt; load the adder carry into the carry register; increment cnt.
REQ-017 In RUN, the edge that processes bit WIDTH-1 SHALL go to DONE.
REQ-018 In DONE, the block SHALL assert done=1 for exactly one cycle, with sum and cout valid.
REQ-019 In DONE, start=1 SHALL be accepted as in REQ-014 (back-to-back operation); start=0 SHALL go to IDLE.
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 start in RUN SHALL be ignored; the captured operands SHALL NOT change.
REQ-022 Latency SHALL be WIDTH cycles: with start accepted at edge k, done is high between edges k+WIDTH and k+WIDTH+1.
REQ-023 sum and cout SHALL hold the last result from DONE through IDLE until the next accepted start.
REQ-024 sum and cout MAY change in RUN.
REQ-025 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap inside one operation.
REQ-026 The result SHALL satisfy {cout,sum} = a + b + cin for all operand values, including all-ones plus all-ones plus 1.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, independent of clk, force: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry register=0, operand registers=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-029 After rst_n rises, the first start SHALL be accepted normally.

Structure
REQ-030 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared header/package serial_add_pkg, together with the default WIDTH.
REQ-031 The full-adder cell SHALL be a separate instantiated combinational sub-module fulladder, with ports a, b, cin, sum, carry.
REQ-032 The block SHALL contain only one fulladder instance.

Verification
REQ-033 With WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulsed at edge 0, the bench SHALL check: busy=1 for 8 cycles; done=1 after edge 8; sum=8'h00; cout=1.
REQ-034 With a=8'hA5, b=8'h5A, cin=1, the bench SHALL check: sum=8'h00, cout=1; then a=8'h00, b=8'h00, cin=0 SHALL give sum=8'h00, cout=0.
REQ-035 With a=8'h12, b=8'h34, and start held high with a=8'hFF applied during RUN, the bench SHALL check: result is sum=8'h46, cout=0; the RUN-time values are ignored.
REQ-036 With start=1 in the DONE cycle and new operands 8'h80+8'h80, the bench SHALL check: busy returns the next cycle; the second done comes 8 cycles later; sum=8'h00; cout=1.
REQ-037 With rst_n driven low mid-RUN, at cycle 4, the bench SHALL check: busy, done, sum and cout go to 0 at once; no done pulse appears; a fresh 8'h03+8'h04 then gives sum=8'h07.
REQ-038 The bench SHALL run a random sweep of at least 200 operand sets against a+b+cin, plus exhaustive checking at WIDTH=2.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: controller states and default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle of the serial adder; the requester drives master, the adder is slave.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit combinational full adder; the serial adder reuses one instance for every bit.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder walks the operands LSB first, one bit per clock,
// and the result is presented with a single-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic               w_faSum;
  logic               w_faCarry;

  fulladder u_fa (
    .a     (r_a[r_cnt]),
    .b     (r_b[r_cnt]),
    .cin   (r_carry),
    .sum   (w_faSum),
    .carry (w_faCarry)
  );

  assign w_last = (r_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A new start is taken from IDLE or straight out of DONE, never while running.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The counter parks on the last bit instead of wrapping; the carry register doubles as cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_sum[r_cnt] <= w_faSum;
      r_carry      <= w_faCarry;
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: directed literal cases, a random sweep against a cycle-level
// arithmetic model at WIDTH=8, and an exhaustive pass over a WIDTH=2 instance.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Arithmetic model: an accepted start yields a+b+cin exactly 8 edges later.
  int         mLeft    = 0;
  bit         mDone    = 1'b0;
  logic [8:0] mResult  = '0;
  logic [8:0] mPending = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLeft   = 0;
      mDone   = 1'b0;
      mResult = '0;
    end else if (mLeft > 0) begin
      mLeft = mLeft - 1;
      mDone = (mLeft == 0);
      if (mDone) mResult = mPending;
    end else begin
      mDone = 1'b0;
      if (bus8.start) begin
        mPending = {1'b0, bus8.a} + {1'b0, bus8.b} + {8'd0, bus8.cin};
        mLeft    = 8;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model busy", {63'd0, bus8.busy}, {63'd0, mLeft > 0});
    checkOutput("model done", {63'd0, bus8.done}, {63'd0, mDone});
    if (mLeft == 0) begin
      checkOutput("model result", {55'd0, bus8.cout, bus8.sum}, {55'd0, mResult});
    end
  end

  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = ta;
    bus8.b     = tb;
    bus8.cin   = tc;
  endtask

  // Called right after applyStimulus (or a chained start); ends on the done cycle.
  task automatic finishOp(input string name, input logic [7:0] expSum, input logic expCout,
                          input bit holdStart, input bit chain,
                          input logic [7:0] na, input logic [7:0] nb, input logic nc);
    @(negedge clk);
    if (holdStart) begin
      bus8.start = 1'b1;
      bus8.a     = 8'hFF;
      bus8.b     = 8'hFF;
    end else begin
      bus8.start = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput({name, " busy"}, {63'd0, bus8.busy}, 64'd1);
      checkOutput({name, " no early done"}, {63'd0, bus8.done}, 64'd0);
      @(negedge clk);
    end
    checkOutput({name, " done"}, {63'd0, bus8.done}, 64'd1);
    checkOutput({name, " busy off"}, {63'd0, bus8.busy}, 64'd0);
    checkOutput({name, " sum"}, {56'd0, bus8.sum}, {56'd0, expSum});
    checkOutput({name, " cout"}, {63'd0, bus8.cout}, {63'd0, expCout});
    if (chain) begin
      bus8.start = 1'b1;
      bus8.a     = na;
      bus8.b     = nb;
      bus8.cin   = nc;
    end else begin
      bus8.start = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] re;
    logic [2:0] e2;

    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus2.start = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;
    bus2.cin   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {63'd0, bus8.busy}, 64'd0);
    checkOutput("reset done", {63'd0, bus8.done}, 64'd0);
    checkOutput("reset sum", {56'd0, bus8.sum}, 64'd0);
    checkOutput("reset cout", {63'd0, bus8.cout}, 64'd0);
    rst_n = 1'b1;

    applyStimulus(8'hFF, 8'h01, 1'b0);
    finishOp("ff+01", 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    applyStimulus(8'hA5, 8'h5A, 1'b1);
    finishOp("a5+5a+1", 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    finishOp("00+00", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    applyStimulus(8'h12, 8'h34, 1'b0);
    finishOp("start held", 8'h46, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    applyStimulus(8'h12, 8'h34, 1'b0);
    finishOp("chain first", 8'h46, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
    finishOp("chain 80+80", 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("idle hold sum", {56'd0, bus8.sum}, 64'd0);
    checkOutput("idle hold cout", {63'd0, bus8.cout}, 64'd1);

    applyStimulus(8'h12, 8'h34, 1'b0);
    finishOp("pre-reset", 8'h46, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {63'd0, bus8.busy}, 64'd0);
    checkOutput("abort done", {63'd0, bus8.done}, 64'd0);
    checkOutput("abort sum", {56'd0, bus8.sum}, 64'd0);
    checkOutput("abort cout", {63'd0, bus8.cout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("abort no done", {63'd0, bus8.done}, 64'd0);
    end
    applyStimulus(8'h03, 8'h04, 1'b0);
    finishOp("03+04", 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      re = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(ra, rb, rc);
      finishOp("random", re[7:0], re[8], 1'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    end

    for (int xa = 0; xa < 4; xa++) begin
      for (int xb = 0; xb < 4; xb++) begin
        for (int xc = 0; xc < 2; xc++) begin
          e2 = 3'(xa + xb + xc);
          @(negedge clk);
          bus2.start = 1'b1;
          bus2.a     = 2'(xa);
          bus2.b     = 2'(xb);
          bus2.cin   = 1'(xc);
          @(negedge clk);
          bus2.start = 1'b0;
          checkOutput("w2 busy0", {63'd0, bus2.busy}, 64'd1);
          @(negedge clk);
          checkOutput("w2 busy1", {63'd0, bus2.busy}, 64'd1);
          @(negedge clk);
          checkOutput("w2 done", {63'd0, bus2.done}, 64'd1);
          checkOutput("w2 result", {61'd0, bus2.cout, bus2.sum}, {61'd0, e2});
        end
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
